// File: rtl/bcd_to_excess3_conv.sv
// Single-digit BCD to Excess-3 converter with one registered output stage.
// Define BCD2XS3_ERRCNT_EN to add a saturating invalid-input counter (err_count).
module bcd_to_excess3_conv #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
`ifdef BCD2XS3_ERRCNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic                 out_valid,
  output logic                 w,
  output logic                 x,
  output logic                 y,
  output logic                 z,
  output logic                 err
);

  logic       inv;
  logic [3:0] sop;
  logic       vld_d, vld_q;
  logic [3:0] code_d, code_q;
  logic       err_d, err_q;

  // Minimised sum-of-products; only meaningful for digits 0..9.
  assign sop[3] = a | (b & c) | (b & d);
  assign sop[2] = (~b & c) | (~b & d) | (b & ~c & ~d);
  assign sop[1] = (c & d) | (~c & ~d);
  assign sop[0] = ~d;
  assign inv    = a & (b | c);

  always_comb begin
    vld_d  = in_valid;
    code_d = code_q;
    err_d  = err_q;
    if (in_valid) begin
      code_d = inv ? 4'b0000 : sop;
      err_d  = inv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      code_q <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
      err_q  <= err_d;
    end
  end

  assign out_valid      = vld_q;
  assign {w, x, y, z}   = code_q;
  assign err            = err_q;

`ifdef BCD2XS3_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && inv) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

  if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    $error("ERR_CNT_W must be at least 1");
  end

endmodule

// File: tb/tb_bcd_to_excess3_conv.sv
// Scoreboard bench for bcd_to_excess3_conv: stimulus queues expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_bcd_to_excess3_conv;
`ifdef BCD2XS3_ERRCNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic out_valid, w, x, y, z, err;
`ifdef BCD2XS3_ERRCNT_EN
  logic [CW-1:0] err_count;
`endif

  bcd_to_excess3_conv #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
`ifdef BCD2XS3_ERRCNT_EN
    .err_count (err_count),
`endif
    .out_valid (out_valid),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [4:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed Excess-3 codes for digits 0..9.
  logic [3:0] xs3_tab [10] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs right after a negedge, queue the expected result, wait for the next negedge.
  task automatic drive(input logic r, input logic v, input logic [3:0] dig, input logic [4:0] expv);
    rst = r;
    in_valid = v;
    {a, b, c, d} = dig;
    if (v && !r) exp_q.push_back(expv);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got {err,wxyz}=%b, expected no output", {err, w, x, y, z});
        end else begin
          e = exp_q.pop_front();
          check("result", {3'b0, err, w, x, y, z}, {3'b0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    @(negedge clk);
    // Reset with a valid digit present: reset must win.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'b0101, 5'b0);
      check("reset_state", {2'b0, out_valid, err, w, x, y, z}, 8'h00);
    end
`ifdef BCD2XS3_ERRCNT_EN
    check("errcnt_reset", {{(8-CW){1'b0}}, err_count}, 8'h00);
`endif

    // Back-to-back sweep of all valid digits.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'(i), {1'b0, xs3_tab[i]});

    // Invalid digits flag err with a zero code.
    drive(1'b0, 1'b1, 4'b1010, 5'b10000);
    drive(1'b0, 1'b1, 4'b1111, 5'b10000);

    // Hold behaviour when in_valid drops.
    drive(1'b0, 1'b1, 4'b0111, 5'b01010);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'b0011, 5'b0);
      check("hold_valid", {7'b0, out_valid}, 8'h00);
      check("hold_data", {3'b0, err, w, x, y, z}, 8'b0000_1010);
    end

    // Reset mid-stream discards the in-flight digit.
    drive(1'b0, 1'b1, 4'b0011, 5'b00110);
    drive(1'b0, 1'b1, 4'b1001, 5'b01100);
    drive(1'b1, 1'b1, 4'b0100, 5'b0);
    check("midreset_state", {2'b0, out_valid, err, w, x, y, z}, 8'h00);
    drive(1'b0, 1'b0, 4'b0000, 5'b0);
    check("postreset_idle", {2'b0, out_valid, err, w, x, y, z}, 8'h00);

    // Valid/invalid mix right after reset.
    drive(1'b0, 1'b1, 4'b1000, 5'b01011);
    drive(1'b0, 1'b1, 4'b1100, 5'b10000);
    drive(1'b0, 1'b1, 4'b0000, 5'b00011);

`ifdef BCD2XS3_ERRCNT_EN
    drive(1'b1, 1'b0, 4'b0000, 5'b0);
    check("errcnt_clear0", {{(8-CW){1'b0}}, err_count}, 8'h00);
    begin
      logic [3:0] bad [5] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};
      logic [7:0] want [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, 1'b1, bad[i], 5'b10000);
        check("errcnt_sat", {{(8-CW){1'b0}}, err_count}, want[i]);
      end
    end
    drive(1'b1, 1'b0, 4'b0000, 5'b0);
    check("errcnt_clear1", {{(8-CW){1'b0}}, err_count}, 8'h00);
`endif

    drive(1'b0, 1'b0, 4'b0000, 5'b0);
    drive(1'b0, 1'b0, 4'b0000, 5'b0);
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
